// File: rtl/uart_debug_pkg.sv
// rtl/uart_debug_pkg.sv - shared opcodes, state encoding and helpers for the UART debug stages
package uart_debug_pkg;

    localparam int ADDR_W_DEFAULT = 18;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h83;
    localparam logic [7:0] OP_LED   = 8'h01;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR_HI  = 4'd1,
        ST_ADDR_LO  = 4'd2,
        ST_DATA_HI  = 4'd3,
        ST_DATA_LO  = 4'd4,
        ST_LED_ARG  = 4'd5,
        ST_MEM_REQ  = 4'd6,
        ST_MEM_WAIT = 4'd7,
        ST_TX_HI    = 4'd8,
        ST_TX_LO    = 4'd9
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    // States that are waiting on a host byte and therefore subject to the inter-byte timeout
    function automatic logic is_arg_state(input state_t s);
        return s inside {ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO, ST_LED_ARG};
    endfunction

endpackage

// File: rtl/uart_debug_timeout.sv
// rtl/uart_debug_timeout.sv - loadable down-counter flagging expiry while enabled
module uart_debug_timeout #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A clear in the same cycle always wins over expiry
    assign expired = enable && !clear && (count_q == '0);

endmodule

// File: rtl/uart_debug_cmd_parser.sv
// rtl/uart_debug_cmd_parser.sv - UART byte stream to SRAM/LED command parser with read-back
module uart_debug_cmd_parser
    import uart_debug_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ADDR_W         = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [15:0]       mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [15:0]       mem_rsp_rdata,
    output logic [3:0]        leds,
    output logic [7:0]        err_count
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [3:0]  leds_q, leds_d;
    logic [7:0]  err_q, err_d;

    logic byte_acc;
    logic opcode_mem;
    logic to_clear;
    logic to_enable;
    logic to_expired;

    assign byte_acc   = rx_valid && rx_ready;
    assign opcode_mem = (rx_data == OP_READ) || (rx_data == OP_WRITE);
    assign to_clear   = byte_acc || !is_arg_state(state_q);
    assign to_enable  = is_arg_state(state_q) && !byte_acc;

    // Expiry after TIMEOUT_CYCLES idle cycles: loaded to N-1, fires while reading zero
    uart_debug_timeout #(
        .CNT_W (TO_W)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (to_clear),
        .enable     (to_enable),
        .load_value (TO_W'(TIMEOUT_CYCLES - 1)),
        .expired    (to_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            leds_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            leds_q  <= leds_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_acc) begin
                    if (opcode_mem) begin
                        state_d = ST_ADDR_HI;
                    end else if (rx_data == OP_LED) begin
                        state_d = ST_LED_ARG;
                    end
                end
            end
            ST_ADDR_HI: begin
                if (byte_acc) state_d = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
                if (byte_acc) state_d = we_q ? ST_DATA_HI : ST_MEM_REQ;
            end
            ST_DATA_HI: begin
                if (byte_acc) state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (byte_acc) state_d = ST_MEM_REQ;
            end
            ST_LED_ARG: begin
                if (byte_acc) state_d = ST_IDLE;
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) state_d = we_q ? ST_IDLE : ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (mem_rsp_valid) state_d = ST_TX_HI;
            end
            ST_TX_HI: begin
                if (tx_ready) state_d = ST_TX_LO;
            end
            ST_TX_LO: begin
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (to_expired) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        leds_d  = leds_q;
        err_d   = err_q;
        if (byte_acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (opcode_mem) begin
                        we_d = (rx_data == OP_WRITE);
                    end else if (rx_data != OP_LED) begin
                        err_d = sat_inc8(err_q);
                    end
                end
                ST_ADDR_HI: addr_d  = {rx_data, addr_q[7:0]};
                ST_ADDR_LO: addr_d  = {addr_q[15:8], rx_data};
                ST_DATA_HI: wdata_d = {rx_data, wdata_q[7:0]};
                ST_DATA_LO: wdata_d = {wdata_q[15:8], rx_data};
                ST_LED_ARG: leds_d  = rx_data[3:0];
                default: ;
            endcase
        end
        if ((state_q == ST_MEM_WAIT) && mem_rsp_valid) begin
            rdata_d = mem_rsp_rdata;
        end
        // A timed-out command leaves no partial fields behind
        if (to_expired) begin
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            err_d   = sat_inc8(err_q);
        end
    end

    always_comb begin
        rx_ready      = 1'b0;
        tx_valid      = 1'b0;
        mem_req_valid = 1'b0;
        tx_data       = 8'h00;
        case (state_q)
            ST_IDLE, ST_ADDR_HI, ST_ADDR_LO,
            ST_DATA_HI, ST_DATA_LO, ST_LED_ARG: rx_ready = 1'b1;
            ST_MEM_REQ: mem_req_valid = 1'b1;
            ST_TX_HI: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q[15:8];
            end
            ST_TX_LO: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q[7:0];
            end
            default: ;
        endcase
    end

    assign mem_req_we    = we_q;
    assign mem_req_addr  = ADDR_W'(addr_q);
    assign mem_req_wdata = wdata_q;
    assign leds          = leds_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_uart_debug_cmd_parser.sv
// tb/tb_uart_debug_cmd_parser.sv - scoreboard bench for the UART debug command parser
module tb_uart_debug_cmd_parser;

    localparam int TO = 20;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [17:0] mem_req_addr;
    logic [15:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_rdata;
    logic [3:0]  leds;
    logic [7:0]  err_count;

    uart_debug_cmd_parser #(
        .TIMEOUT_CYCLES (TO),
        .ADDR_W         (18)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .leds          (leds),
        .err_count     (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        we;
        logic [17:0] addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        string       name;
        int          n;
        logic [39:0] bytes;
        logic        is_req;
        logic        we;
        logic [17:0] addr;
        logic [15:0] wdata;
        int          ntx;
        logic [15:0] rd;
        logic [3:0]  leds;
        logic [7:0]  err;
    } vec_t;

    int          checks;
    int          errors;
    req_t        req_q[$];
    logic [7:0]  tx_q[$];
    logic [15:0] sram [int];
    logic        rsp_pending;
    logic        rsp_enable;
    logic [15:0] rsp_data;
    logic        prev_req_hold;
    logic        prev_tx_hold;
    req_t        prev_req;
    logic [7:0]  prev_tx;
    logic [7:0]  exp_err;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        req_t        e;
        logic [7:0]  b;
        if (prev_req_hold) begin
            chk("req_hold_valid", 64'(mem_req_valid), 64'(1));
            chk("req_hold_fields", 64'({mem_req_we, mem_req_addr, mem_req_wdata}), 64'(prev_req));
        end
        if (prev_tx_hold) begin
            chk("tx_hold_data", 64'(tx_data), 64'(prev_tx));
        end
        if (mem_req_valid || tx_valid) begin
            chk("rx_ready_busy", 64'(rx_ready), 64'(0));
        end
        if (mem_req_valid && mem_req_ready) begin
            chk("req_expected", 64'(req_q.size() != 0), 64'(1));
            if (req_q.size() != 0) begin
                e = req_q.pop_front();
                chk("req_we", 64'(mem_req_we), 64'(e.we));
                chk("req_addr", 64'(mem_req_addr), 64'(e.addr));
                if (e.we) chk("req_wdata", 64'(mem_req_wdata), 64'(e.wdata));
            end
            if (mem_req_we) begin
                sram[int'(mem_req_addr)] = mem_req_wdata;
            end else if (rsp_enable) begin
                rsp_pending = 1'b1;
                rsp_data = sram.exists(int'(mem_req_addr)) ? sram[int'(mem_req_addr)]
                                                           : mem_req_addr[15:0];
            end
        end
        if (tx_valid && tx_ready) begin
            chk("tx_expected", 64'(tx_q.size() != 0), 64'(1));
            if (tx_q.size() != 0) begin
                b = tx_q.pop_front();
                chk("tx_byte", 64'(tx_data), 64'(b));
            end
        end
        prev_req_hold = mem_req_valid && !mem_req_ready;
        prev_req      = {mem_req_we, mem_req_addr, mem_req_wdata};
        prev_tx_hold  = tx_valid && !tx_ready;
        prev_tx       = tx_data;
    endtask

    task automatic tick(output logic acc);
        @(negedge clk);
        acc = rx_valid && rx_ready;
        monitor();
        @(posedge clk);
        #1;
        mem_rsp_valid = rsp_pending;
        mem_rsp_rdata = rsp_data;
        rsp_pending   = 1'b0;
    endtask

    task automatic step();
        logic a;
        tick(a);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic a;
        a = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !a; i++) tick(a);
        chk("rx_accept", 64'(a), 64'(1));
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input int n, input logic [39:0] bytes);
        for (int i = 0; i < n; i++) send_byte(bytes[39-8*i -: 8]);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (req_q.size() == 0 && tx_q.size() == 0 && !rsp_pending && !mem_rsp_valid &&
                rx_ready && !mem_req_valid && !tx_valid) done = 1'b1;
            else step();
        end
        chk({"idle_", name}, 64'(done), 64'(1));
    endtask

    task automatic push_req(input logic we, input logic [17:0] addr, input logic [15:0] wdata);
        req_t r;
        r.we = we;
        r.addr = addr;
        r.wdata = wdata;
        req_q.push_back(r);
    endtask

    task automatic push_tx(input logic [15:0] v);
        tx_q.push_back(v[15:8]);
        tx_q.push_back(v[7:0]);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_rx_ready"}, 64'(rx_ready), 64'(1));
        chk({p, "_tx_valid"}, 64'(tx_valid), 64'(0));
        chk({p, "_req_valid"}, 64'(mem_req_valid), 64'(0));
        chk({p, "_req_we"}, 64'(mem_req_we), 64'(0));
        chk({p, "_req_addr"}, 64'(mem_req_addr), 64'(0));
        chk({p, "_req_wdata"}, 64'(mem_req_wdata), 64'(0));
        chk({p, "_tx_data"}, 64'(tx_data), 64'(0));
        chk({p, "_leds"}, 64'(leds), 64'(0));
        chk({p, "_err"}, 64'(err_count), 64'(0));
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_req) push_req(v.we, v.addr, v.wdata);
        if (v.ntx != 0) push_tx(v.rd);
        send_cmd(v.n, v.bytes);
        wait_idle(v.name);
        chk({v.name, "_leds"}, 64'(leds), 64'(v.leds));
        chk({v.name, "_err"}, 64'(err_count), 64'(v.err));
    endtask

    initial begin
        logic seen;
        checks = 0;
        errors = 0;
        rsp_pending = 1'b0;
        rsp_enable = 1'b1;
        rsp_data = '0;
        prev_req_hold = 1'b0;
        prev_tx_hold = 1'b0;
        prev_req = '0;
        prev_tx = '0;
        rst_n = 1'b0;
        rx_data = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;

        vecs[0] = '{"read",     3, 40'h0376480000, 1'b1, 1'b0, 18'h07648, 16'h0000, 2, 16'h7648, 4'h0, 8'h00};
        vecs[1] = '{"write",    5, 40'h83FFFFAA55, 1'b1, 1'b1, 18'h0FFFF, 16'hAA55, 0, 16'h0000, 4'h0, 8'h00};
        vecs[2] = '{"bad_op",   1, 40'h0200000000, 1'b0, 1'b0, 18'h00000, 16'h0000, 0, 16'h0000, 4'h0, 8'h01};
        vecs[3] = '{"led_b",    2, 40'h010B000000, 1'b0, 1'b0, 18'h00000, 16'h0000, 0, 16'h0000, 4'hB, 8'h01};
        vecs[4] = '{"resync",   3, 40'h0312340000, 1'b1, 1'b0, 18'h01234, 16'h0000, 2, 16'h1234, 4'hB, 8'h01};
        vecs[5] = '{"readback", 3, 40'h03FFFF0000, 1'b1, 1'b0, 18'h0FFFF, 16'h0000, 2, 16'hAA55, 4'hB, 8'h01};
        vecs[6] = '{"bad_ff",   1, 40'hFF00000000, 1'b0, 1'b0, 18'h00000, 16'h0000, 0, 16'h0000, 4'hB, 8'h02};
        vecs[7] = '{"led_5",    2, 40'h01F5000000, 1'b0, 1'b0, 18'h00000, 16'h0000, 0, 16'h0000, 4'h5, 8'h02};

        step();
        step();
        check_reset("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        exp_err = 8'h02;

        // Timeout: no request, error counted exactly on the TO-th idle cycle
        send_cmd(2, 40'h83DE000000);
        for (int i = 0; i < TO - 1; i++) step();
        chk("to_before_err", 64'(err_count), 64'(exp_err));
        chk("to_before_rx_ready", 64'(rx_ready), 64'(1));
        step();
        exp_err = exp_err + 8'h01;
        chk("to_err", 64'(err_count), 64'(exp_err));
        chk("to_no_req", 64'(mem_req_valid), 64'(0));
        push_req(1'b0, 18'h00010, 16'h0000);
        push_tx(16'h0010);
        send_cmd(3, 40'h0300100000);
        wait_idle("after_to");
        chk("after_to_err", 64'(err_count), 64'(exp_err));

        // A byte arriving on the expiry cycle wins
        push_req(1'b0, 18'h00042, 16'h0000);
        push_tx(16'h0042);
        send_byte(8'h03);
        for (int i = 0; i < TO - 1; i++) step();
        send_byte(8'h00);
        send_byte(8'h42);
        wait_idle("to_edge");
        chk("to_edge_err", 64'(err_count), 64'(exp_err));

        // Backpressure on request and response
        mem_req_ready = 1'b0;
        tx_ready = 1'b0;
        push_req(1'b0, 18'h0ABCD, 16'h0000);
        push_tx(16'hABCD);
        send_cmd(3, 40'h03ABCD0000);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_valid", 64'(mem_req_valid), 64'(1));
            step();
        end
        mem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !tx_valid; i++) step();
        chk("bp_tx_rise", 64'(tx_valid), 64'(1));
        for (int i = 0; i < 7; i++) begin
            chk("bp_tx_valid", 64'(tx_valid), 64'(1));
            chk("bp_tx_data", 64'(tx_data), 64'(8'hAB));
            step();
        end
        tx_ready = 1'b1;
        wait_idle("bp");

        // Reset while waiting for read data
        rsp_enable = 1'b0;
        push_req(1'b0, 18'h00020, 16'h0000);
        send_cmd(3, 40'h0300200000);
        for (int i = 0; i < 20 && req_q.size() != 0; i++) step();
        chk("wait_req_done", 64'(req_q.size()), 64'(0));
        chk("wait_rx_ready", 64'(rx_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        step();
        step();
        rst_n = 1'b1;
        rsp_enable = 1'b1;
        prev_req_hold = 1'b0;
        prev_tx_hold = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 16'hBEEF;
        step();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (tx_valid) seen = 1'b1;
            step();
        end
        chk("late_rsp_no_tx", 64'(seen), 64'(0));
        push_req(1'b0, 18'h00030, 16'h0000);
        push_tx(16'h0030);
        send_cmd(3, 40'h0300300000);
        wait_idle("post_reset");
        chk("post_reset_err", 64'(err_count), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_debug_cmd_parser.md
# uart_debug_cmd_parser

Byte-level command parser between the UART receiver and the SRAM access port of the UART debug top. It consumes the received byte stream through a valid/ready handshake and assembles read, write and LED commands. It issues single-word SRAM requests and serialises read data back to the UART transmitter as two bytes. An inter-byte timeout discards partial commands so that a corrupted host stream resynchronises.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed between bytes of one command before it is discarded (must be ≥2).
- `ADDR_W`, 18: SRAM word-address width; the command carries 16 bits, zero-extended.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  parser accepts `rx_data` this cycle.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts the byte.
- `mem_req_valid`  out  1  SRAM request pending.
- `mem_req_ready`  in  1  SRAM controller accepts the request.
- `mem_req_we`  out  1  1 = write, 0 = read.
- `mem_req_addr`  out  ADDR_W  word address.
- `mem_req_wdata`  out  16  write data.
- `mem_rsp_valid`  in  1  one-cycle pulse; read data is valid.
- `mem_rsp_rdata`  in  16  read data.
- `leds`  out  4  LED register.
- `err_count`  out  8  count of unknown opcodes plus timeouts; saturates at 0xFF.

## Operation
- Byte transfer: a byte transfers on a cycle with `rx_valid & rx_ready`.
- Opcodes:
  - 0x03 read: followed by ADDR_HI, ADDR_LO.
  - 0x83 write: followed by ADDR_HI, ADDR_LO, DATA_HI, DATA_LO.
  - 0x01 LED: followed by one byte; `leds` takes its bits [3:0].
  - Any other opcode is consumed, dropped and increments `err_count`; the state stays IDLE.
- Byte order: all multi-byte fields are big-endian. The address is {2'b00, hi, lo}.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, LED_ARG, MEM_REQ, MEM_WAIT, TX_HI, TX_LO.
- Transitions:
  - IDLE → ADDR_HI on 0x03 or 0x83; the write flag is latched.
  - IDLE → LED_ARG on 0x01.
  - ADDR_HI → ADDR_LO.
  - ADDR_LO → MEM_REQ for a read, or → DATA_HI for a write.
  - DATA_HI → DATA_LO → MEM_REQ.
  - MEM_REQ → IDLE for a write, or → MEM_WAIT for a read, on `mem_req_ready`.
  - MEM_WAIT → TX_HI on `mem_rsp_valid`; the data is latched.
  - TX_HI → TX_LO → IDLE, each advancing on `tx_ready`.
  - LED_ARG → IDLE.
- `rx_ready` is 1 exactly in IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO and LED_ARG. There is no byte lookahead.
- `mem_req_valid` is 1 only in MEM_REQ. `mem_req_*` fields stay stable while `mem_req_valid` is held.
- `tx_valid` is 1 only in TX_HI and TX_LO. `tx_data` is rdata[15:8] in TX_HI and rdata[7:0] in TX_LO.
- Timeout:
  - The counter resets on every accepted byte and in IDLE. It counts only in ADDR_HI..LED_ARG.
  - On reaching `TIMEOUT_CYCLES` the FSM goes to IDLE, partial fields are discarded and `err_count` increments.
  - MEM_REQ, MEM_WAIT and the TX states have no timeout.
- A `mem_rsp_valid` outside MEM_WAIT is ignored.

## Timing
- Reset values: state IDLE; `rx_ready` 1; `tx_valid` 0; `mem_req_valid` 0; `mem_req_we` 0; `mem_req_addr` 0; `mem_req_wdata` 0; `tx_data` 0; `leds` 0; `err_count` 0.
- Reset is asynchronous and may assert in any state. An in-flight request or response is abandoned with no output glitch beyond the reset values.
- Request latency: `mem_req_valid` rises the cycle after the last address or data byte is accepted.
- Response latency: `tx_valid` rises the cycle after `mem_rsp_valid`.
- LED latency: `leds` updates the cycle after the LED argument is accepted.
- Throughput: one byte per cycle is accepted while in the argument states.
- Simultaneous events:
  - Timeout and byte acceptance in the same cycle: the byte wins and no error is counted.
  - Error increment at 0xFF: `err_count` holds 0xFF.

## Structure
- Shared package `uart_debug_pkg`:
  - opcode constants `OP_READ` = 8'h03, `OP_WRITE` = 8'h83, `OP_LED` = 8'h01.
  - FSM state encoding.
  - `ADDR_W` default.
- Sub-module `uart_debug_timeout`: a loadable down-counter with `clear`, `enable` and `expired`, reused by other debug stages.

## Test plan
- Read: 0x03 0x76 0x48 with SRAM model returning 0x7648 → one request with we=0, addr=18'h07648; tx emits 0x76 then 0x48; back to IDLE.
- Write: 0x83 0xFF 0xFF 0xAA 0x55 → one request with we=1, addr=18'h0FFFF, wdata=0xAA55; no tx bytes.
- Bad opcode and LED: 0x02, then 0x01 0x0B → `err_count`=1 and `leds`=4'hB. Then 0x03 0x12 0x34 reads correctly, showing the parser resynchronised.
- Timeout:
  - 0x83 0xDE, then silence for `TIMEOUT_CYCLES` → `err_count`+1, no request issued.
  - A subsequent 0x03 0x00 0x10 returns 0x00 0x10.
- Backpressure: hold `mem_req_ready` low 5 cycles and `tx_ready` low 7 cycles → request fields and `tx_data` stay stable while held; `rx_ready`=0 throughout.
- Reset: assert `rst_n`=0 while in MEM_WAIT → all outputs at reset values immediately. After release, a late `mem_rsp_valid` produces no tx.
